uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_pkg.sv | 31 +++
 rtl/sync_fifo.sv | 52 +++++
 rtl/uart_rx_fifo.sv | 151 +++++++++++++++
 tb/tb_uart_rx_fifo.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM states, parity modes and
// the bit-period divider calculation.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } rx_state_e;

    typedef enum logic [1:0] {
        PAR_NONE,
        PAR_EVEN,
        PAR_ODD
    } parity_e;

    // Bit period in clocks, rounded to nearest.
    function automatic int unsigned calc_div(input int unsigned clk_freq,
                                             input int unsigned baud_rate);
        return (clk_freq + baud_rate / 2) / baud_rate;
    endfunction

    function automatic parity_e parity_mode(input string mode);
        if (mode == "EVEN") return PAR_EVEN;
        if (mode == "ODD")  return PAR_ODD;
        return PAR_NONE;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered head word; a push into an empty FIFO
// shows up on dout/valid one clock later.
module sync_fifo #(
    parameter int DATA_W = 10,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              ready,
    output logic [DATA_W-1:0] dout,
    output logic              valid,
    output logic              overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr, rd_next;
    logic [CW-1:0]     count;
    logic              full, pop, wr_en;

    assign valid   = (count != '0);
    assign full    = (count == CW'(DEPTH));
    assign pop     = ready && valid;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign wr_en   = push && (!full || pop);
    assign rd_next = pop ? rd_ptr + AW'(1) : rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            dout     <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            rd_ptr   <= rd_next;
            count    <= count + CW'(wr_en) - CW'(pop);
            overflow <= push && full && !pop;
            // Forward the incoming word when it lands exactly at the new head.
            dout     <= (wr_en && (wr_ptr == rd_next)) ? din : mem[rd_next];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with configurable framing, feeding received words and their
// parity/stop-bit error flags into a small FIFO.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ    = 50_000_000,
    parameter int unsigned BAUD_RATE   = 115200,
    parameter int unsigned WORD_LENGTH = 8,
    parameter int unsigned STOP_BITS   = 2,
    parameter string       PARITY      = "NONE",
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rx,
    output logic [WORD_LENGTH-1:0] out_data,
    output logic                   out_parity_err,
    output logic                   out_frame_err,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   overrun,
    output logic                   busy
);
    localparam int unsigned      DIV       = calc_div(CLK_FREQ, BAUD_RATE);
    localparam int               CNT_W     = $clog2(DIV);
    localparam logic [CNT_W-1:0] DIV_M1    = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF_M1   = CNT_W'(DIV / 2 - 1);
    localparam parity_e          PMODE     = parity_mode(PARITY);
    localparam logic [3:0]       LAST_BIT  = 4'(WORD_LENGTH - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);
    localparam int               FW        = WORD_LENGTH + 2;

    rx_state_e              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [3:0]             bit_q, bit_d;
    logic                   stop_q, stop_d;
    logic [WORD_LENGTH-1:0] shift_q, shift_d;
    logic                   perr_q, perr_d, ferr_q, ferr_d;
    logic                   rx_p0, rx_p1, rx_p2;
    logic                   tick, push;
    logic [FW-1:0]          push_word, head;

    // rx_p1 is the synchronised line; rx_p2 is its previous value for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_p0   <= 1'b1;
            rx_p1   <= 1'b1;
            rx_p2   <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
        end else begin
            rx_p0   <= rx;
            rx_p1   <= rx_p0;
            rx_p2   <= rx_p1;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        perr_q  <= perr_d;
        ferr_q  <= ferr_d;
    end

    assign tick = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = tick ? cnt_q : cnt_q - 1'b1;
        bit_d   = bit_q;
        stop_d  = stop_q;
        shift_d = shift_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_p2 && !rx_p1) begin
                    state_d = START;
                    cnt_d   = HALF_M1;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                end
            end
            START: begin
                if (tick) begin
                    state_d = rx_p1 ? IDLE : DATA;
                    cnt_d   = DIV_M1;
                    bit_d   = '0;
                    stop_d  = 1'b0;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d = {rx_p1, shift_q[WORD_LENGTH-1:1]};
                    cnt_d   = DIV_M1;
                    bit_d   = bit_q + 4'd1;
                    if (bit_q == LAST_BIT) state_d = (PMODE == PAR_NONE) ? STOP : PAR;
                end
            end
            PAR: begin
                if (tick) begin
                    perr_d  = (^shift_q) ^ rx_p1 ^ (PMODE == PAR_ODD);
                    cnt_d   = DIV_M1;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    cnt_d = DIV_M1;
                    if (stop_q == LAST_STOP) begin
                        state_d = IDLE;
                        push    = 1'b1;
                    end else begin
                        stop_d = stop_q + 1'b1;
                        ferr_d = ferr_q | ~rx_p1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The final stop sample is folded straight into the pushed frame flag.
    assign push_word = {shift_q, perr_q, ferr_q | ~rx_p1};

    sync_fifo #(
        .DATA_W (FW),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .din      (push_word),
        .ready    (out_ready),
        .dout     (head),
        .valid    (out_valid),
        .overflow (overrun)
    );

    assign out_data       = head[FW-1:2];
    assign out_parity_err = head[1];
    assign out_frame_err  = head[0];
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench: dut0 runs the default 8N2 framing, dut1 runs 8E1 at a
// faster baud rate with randomised frames and a randomly stalling consumer.
module tb_uart_rx_fifo;
    localparam int CLK_FREQ = 50_000_000;
    localparam int BAUD0    = 115200;
    localparam int BAUD1    = 1_000_000;
    localparam int BIT0     = (CLK_FREQ + BAUD0 / 2) / BAUD0;
    localparam int BIT1     = (CLK_FREQ + BAUD1 / 2) / BAUD1;
    localparam int DEPTH    = 4;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic       rst0_n = 1'b1, rst1_n = 1'b1;
    logic       rx0 = 1'b1, rx1 = 1'b1, rdy0 = 1'b1, rdy1 = 1'b1;
    logic [7:0] data0, data1;
    logic       pe0, fe0, v0, ovr0, busy0;
    logic       pe1, fe1, v1, ovr1, busy1;

    uart_rx_fifo #(
        .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD0)
    ) dut0 (
        .clk(clk), .rst_n(rst0_n), .rx(rx0), .out_data(data0),
        .out_parity_err(pe0), .out_frame_err(fe0), .out_valid(v0),
        .out_ready(rdy0), .overrun(ovr0), .busy(busy0)
    );

    uart_rx_fifo #(
        .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD1), .WORD_LENGTH(8),
        .STOP_BITS(1), .PARITY("EVEN"), .FIFO_DEPTH(DEPTH)
    ) dut1 (
        .clk(clk), .rst_n(rst1_n), .rx(rx1), .out_data(data1),
        .out_parity_err(pe1), .out_frame_err(fe1), .out_valid(v1),
        .out_ready(rdy1), .overrun(ovr1), .busy(busy1)
    );

    int         n_cmp = 0, n_fail = 0;
    logic [9:0] exp0[$], exp1[$];
    logic [9:0] e0, e1;
    int         exp_ovr0 = 0, exp_ovr1 = 0, ovr_cnt0 = 0, ovr_cnt1 = 0;
    bit         done0 = 0, done1 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: a word is expected unless DEPTH words are already waiting.
    task automatic expect_word(input int sel, input logic [9:0] w);
        if (sel == 0) begin
            if (exp0.size() < DEPTH) exp0.push_back(w); else exp_ovr0++;
        end else begin
            if (exp1.size() < DEPTH) exp1.push_back(w); else exp_ovr1++;
        end
    endtask

    task automatic drive(input int sel, input logic b, input int n);
        if (sel == 0) rx0 = b; else rx1 = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // sel 0: 8 data bits, 2 stop bits; sel 1: 8 data bits, even parity, 1 stop bit.
    task automatic send(input int sel, input logic [7:0] d, input logic pbit,
                        input logic s0, input logic s1);
        int         bt;
        logic       pe, fe;
        bt = (sel == 0) ? BIT0 : BIT1;
        pe = (sel == 0) ? 1'b0 : ((^d) ^ pbit);
        fe = !s0 || (sel == 0 && !s1);
        expect_word(sel, {d, pe, fe});
        drive(sel, 1'b0, bt);
        for (int i = 0; i < 8; i++) drive(sel, d[i], bt);
        if (sel == 1) drive(sel, pbit, bt);
        drive(sel, s0, bt);
        if (sel == 0) drive(sel, s1, bt);
        drive(sel, 1'b1, 20);
    endtask

    task automatic line_break(input int sel);
        int bt;
        bt = (sel == 0) ? BIT0 : BIT1;
        expect_word(sel, {8'h00, 1'b0, 1'b1});
        drive(sel, 1'b0, bt * 14);
        drive(sel, 1'b1, bt * 2);
    endtask

    task automatic wait_drain(input int sel);
        int i;
        for (i = 0; i < 4000; i++) begin
            if (sel == 0 && exp0.size() == 0 && !v0) break;
            if (sel == 1 && exp1.size() == 0 && !v1) break;
            @(posedge clk);
            #1;
        end
        chk($sformatf("dut%0d drained", sel), 32'(i < 4000), 32'd1);
    endtask

    task automatic chk_reset(input int sel);
        if (sel == 0) begin
            chk("dut0 reset out_data", 32'(data0), 0);
            chk("dut0 reset parity_err", 32'(pe0), 0);
            chk("dut0 reset frame_err", 32'(fe0), 0);
            chk("dut0 reset out_valid", 32'(v0), 0);
            chk("dut0 reset overrun", 32'(ovr0), 0);
            chk("dut0 reset busy", 32'(busy0), 0);
        end else begin
            chk("dut1 reset out_data", 32'(data1), 0);
            chk("dut1 reset parity_err", 32'(pe1), 0);
            chk("dut1 reset frame_err", 32'(fe1), 0);
            chk("dut1 reset out_valid", 32'(v1), 0);
            chk("dut1 reset overrun", 32'(ovr1), 0);
            chk("dut1 reset busy", 32'(busy1), 0);
        end
    endtask

    // Monitors: every accepted head word is compared with the oldest expectation.
    always @(negedge clk) begin
        if (rst0_n && v0 && rdy0) begin
            if (exp0.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL dut0 unexpected word: got 0x%0h, required none", {data0, pe0, fe0});
            end else begin
                e0 = exp0.pop_front();
                chk("dut0 word {data,perr,ferr}", 32'({data0, pe0, fe0}), 32'(e0));
            end
        end
        if (rst0_n && ovr0) ovr_cnt0++;
    end

    always @(negedge clk) begin
        if (rst1_n && v1 && rdy1) begin
            if (exp1.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL dut1 unexpected word: got 0x%0h, required none", {data1, pe1, fe1});
            end else begin
                e1 = exp1.pop_front();
                chk("dut1 word {data,perr,ferr}", 32'({data1, pe1, fe1}), 32'(e1));
            end
        end
        if (rst1_n && ovr1) ovr_cnt1++;
    end

    initial begin : seq0
        bit         hi, gone;
        logic [7:0] d;
        #5 rst0_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk_reset(0);
        rst0_n = 1'b1;
        drive(0, 1'b1, 20);

        send(0, 8'hFA, 1'b0, 1'b1, 1'b1);
        send(0, 8'hA5, 1'b0, 1'b1, 1'b1);
        wait_drain(0);

        send(0, 8'h3C, 1'b0, 1'b0, 1'b1);
        send(0, 8'h55, 1'b0, 1'b1, 1'b1);
        wait_drain(0);

        // 2000 ns low pulse on an idle line
        hi   = 0;
        gone = 0;
        rx0  = 1'b0;
        for (int i = 1; i <= BIT0 / 2 + 3; i++) begin
            @(posedge clk);
            #1;
            if (i == 100) rx0 = 1'b1;
            if (busy0) hi = 1;
            else if (hi) begin
                gone = 1;
                break;
            end
        end
        rx0 = 1'b1;
        chk("dut0 glitch busy rose", 32'(hi), 1);
        chk("dut0 glitch busy fell in time", 32'(gone), 1);
        drive(0, 1'b1, 2 * BIT0);
        chk("dut0 glitch out_valid", 32'(v0), 0);

        line_break(0);
        send(0, 8'h55, 1'b0, 1'b1, 1'b1);
        wait_drain(0);

        rdy0 = 1'b0;
        for (int i = 1; i <= 5; i++) send(0, 8'(i), 1'b0, 1'b1, 1'b1);
        chk("dut0 full out_valid", 32'(v0), 1);
        chk("dut0 overrun pulses", 32'(ovr_cnt0), 32'(exp_ovr0));
        rdy0 = 1'b1;
        wait_drain(0);
        chk("dut0 drained out_valid", 32'(v0), 0);

        // reset in the middle of bit 4 of 0xFF
        drive(0, 1'b0, BIT0);
        drive(0, 1'b1, 4 * BIT0 + BIT0 / 2);
        rst0_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("dut0 midframe reset busy", 32'(busy0), 0);
        chk("dut0 midframe reset out_valid", 32'(v0), 0);
        rst0_n = 1'b1;
        drive(0, 1'b1, 2 * BIT0);
        send(0, 8'h12, 1'b0, 1'b1, 1'b1);
        wait_drain(0);

        d = 8'($urandom);
        send(0, d, 1'b0, 1'b1, 1'($urandom_range(0, 1)));
        wait_drain(0);
        chk("dut0 total overrun pulses", 32'(ovr_cnt0), 32'(exp_ovr0));
        done0 = 1;
    end

    initial begin : seq1
        bit         rnd_done;
        logic [7:0] d;
        #5 rst1_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk_reset(1);
        rst1_n = 1'b1;
        drive(1, 1'b1, 20);

        send(1, 8'hA5, 1'b1, 1'b1, 1'b1);
        send(1, 8'hA5, 1'b0, 1'b1, 1'b1);
        wait_drain(1);

        drive(1, 1'b0, BIT1 / 2 - 5);
        drive(1, 1'b1, 3 * BIT1);
        chk("dut1 glitch out_valid", 32'(v1), 0);
        chk("dut1 glitch busy", 32'(busy1), 0);

        line_break(1);
        send(1, 8'h55, 1'b0, 1'b1, 1'b1);
        wait_drain(1);

        rnd_done = 0;
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    d = 8'($urandom);
                    send(1, d, 1'($urandom_range(0, 1)), $urandom_range(0, 4) != 0, 1'b1);
                    drive(1, 1'b1, $urandom_range(0, 100));
                end
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    rdy1 = ($urandom_range(0, 3) != 0);
                end
            end
        join
        rdy1 = 1'b1;
        wait_drain(1);
        chk("dut1 total overrun pulses", 32'(ovr_cnt1), 32'(exp_ovr1));
        done1 = 1;
    end

    initial begin
        fork
            wait (done0 && done1);
            begin
                repeat (90000) @(posedge clk);
                n_cmp++;
                n_fail++;
                $display("FAIL global timeout: sequences done %0d/%0d, required 1/1", done0, done1);
            end
        join_any
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
